shift_reg_ctl: RTL and testbench
================================

Name: shift_reg_ctl

Overview:
Parametrised multi-mode shift register with a step counter, the next generation of the single-bit Dff storage cell. It holds a WIDTH-bit operand and performs parallel load, arithmetic, logical and rotate shifts under a mode code. It counts shift steps and flags completion after NSTEPS steps. It is intended as the partial-product/multiplier register of the radix-2/radix-4 Booth multiplier feeding the DCT datapath.

Parameters:
WIDTH, 16, register width in bits (>=4)
NSTEPS, 8, shift operations before done asserts (>=1)
CW, $clog2(NSTEPS+1), step counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
clr  input  1  asynchronous active-low reset (0 = reset)
sclr  input  1  synchronous clear, active-high
en  input  1  operation enable; 0 = hold everything
mode  input  3  operation select (see Behaviour)
ld_data  input  WIDTH  parallel load value
sin  input  1  serial input bit for logical shifts
q  output  WIDTH  register contents
sout  output  2  bits shifted out by the last shift (registered)
shift_cnt  output  CW  shift steps completed since last load/clear
done  output  1  high when shift_cnt == NSTEPS; sticky

Behaviour:
- Reset: clr low asynchronously forces q=0, sout=2'b00, shift_cnt=0, done=0. Outputs stay there while clr is low. Release is synchronous to the next edge; no operation occurs on an edge where clr is low.
- Priority per rising edge when clr is high: sclr > en. sclr=1 gives the same state as reset, regardless of en and mode.
- en=0: all state holds, including sout.
- mode codes with en=1:
  - 000 HOLD: no change.
  - 001 LOAD: q<=ld_data, shift_cnt<=0, done<=0, sout<=00. LOAD is accepted even when done=1.
  - 010 ASR1: q<={q[W-1],q[W-1:1]}, sout<={1'b0,q[0]}.
  - 011 ASR2: q<={q[W-1],q[W-1],q[W-1:2]}, sout<=q[1:0].
  - 100 LSR1: q<={sin,q[W-1:1]}, sout<={1'b0,q[0]}.
  - 101 LSL1: q<={q[W-2:0],sin}, sout<={1'b0,q[W-1]}.
  - 110 ROR1: q<={q[0],q[W-1:1]}, sout<={1'b0,q[0]}.
  - 111 reserved: behaves as HOLD.
- Shift ops are 010–110. Each accepted shift op increments shift_cnt by 1; ASR2 counts as one step.
- done is registered. It is set on the edge where shift_cnt goes from NSTEPS-1 to NSTEPS, so it is visible in the same cycle that shift_cnt reads NSTEPS.
- While done=1, shift ops are blocked: q, sout and shift_cnt hold. Only LOAD, sclr or reset clear done.
- shift_cnt never exceeds NSTEPS; no wrap-around.
- Latency: every operation is visible on q/sout/shift_cnt/done one cycle after the sampling edge. No combinational path from inputs to outputs.
- A mode change mid-sequence is legal. The counter counts any shift op regardless of type.

Test Plan:
1. WIDTH=8, NSTEPS=4. Assert clr=0 mid-sequence with q=8'h5A and shift_cnt=2 -> q=00, shift_cnt=0, done=0, sout=00 immediately, before the next clk edge.
2. LOAD 8'hA4, then ASR2 -> q=8'hE9, sout=2'b00, shift_cnt=1. Follow with ASR1 -> q=8'hF4, sout=2'b01, shift_cnt=2.
3. LOAD 8'h81; LSL1 with sin=1 -> q=8'h03, sout=01. LSR1 with sin=1 -> q=8'h81, sout=01. ROR1 -> q=8'hC0, sout=01.
4. LOAD 8'h01, then 4 ROR1 -> done=1 with shift_cnt=4, q=8'h10. A 5th ROR1 -> q stays 8'h10, shift_cnt stays 4. LOAD 8'h33 -> done=0, shift_cnt=0.
5. Apply en=0 with mode=ASR1 for 3 cycles -> no state change. Apply sclr=1 with en=0 and mode=LOAD -> q=00, shift_cnt=0 (sclr wins).
6. mode=111 with en=1 on q=8'h7E -> q unchanged, shift_cnt unchanged.

Source files
------------

// File: rtl/shift_reg_ctl.sv
// Multi-mode WIDTH-bit shift register with a saturating step counter and a sticky done flag.
// Intended as the operand/partial-product register of a Booth multiplier.
module shift_reg_ctl #(
  parameter int WIDTH  = 16,
  parameter int NSTEPS = 8,
  localparam int CW    = $clog2(NSTEPS + 1)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [1:0]       sout,
  output logic [CW-1:0]    shift_cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_LOAD = 3'b001,
    M_ASR1 = 3'b010,
    M_ASR2 = 3'b011,
    M_LSR1 = 3'b100,
    M_LSL1 = 3'b101,
    M_ROR1 = 3'b110,
    M_RSVD = 3'b111
  } mode_t;

  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEPS - 1);

  logic [WIDTH-1:0] r_q;
  logic [1:0]       r_sout;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  logic             w_is_shift;
  logic [WIDTH-1:0] w_q_shift;
  logic [1:0]       w_sout_shift;

  always_comb begin
    w_is_shift   = 1'b1;
    w_q_shift    = r_q;
    w_sout_shift = r_sout;
    case (mode_t'(mode))
      M_ASR1: begin
        w_q_shift    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_sout_shift = {1'b0, r_q[0]};
      end
      M_ASR2: begin
        w_q_shift    = {r_q[WIDTH-1], r_q[WIDTH-1], r_q[WIDTH-1:2]};
        w_sout_shift = r_q[1:0];
      end
      M_LSR1: begin
        w_q_shift    = {sin, r_q[WIDTH-1:1]};
        w_sout_shift = {1'b0, r_q[0]};
      end
      M_LSL1: begin
        w_q_shift    = {r_q[WIDTH-2:0], sin};
        w_sout_shift = {1'b0, r_q[WIDTH-1]};
      end
      M_ROR1: begin
        w_q_shift    = {r_q[0], r_q[WIDTH-1:1]};
        w_sout_shift = {1'b0, r_q[0]};
      end
      default: w_is_shift = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q    <= '0;
      r_sout <= 2'b00;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (sclr) begin
      r_q    <= '0;
      r_sout <= 2'b00;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (en) begin
      if (mode_t'(mode) == M_LOAD) begin
        r_q    <= ld_data;
        r_sout <= 2'b00;
        r_cnt  <= '0;
        r_done <= 1'b0;
      end else if (w_is_shift && !r_done) begin
        // done is exactly "counter at NSTEPS", so blocking on it also saturates the count
        r_q    <= w_q_shift;
        r_sout <= w_sout_shift;
        r_cnt  <= r_cnt + CW'(1);
        if (r_cnt == LAST_STEP) r_done <= 1'b1;
      end
    end
  end

  assign q         = r_q;
  assign sout      = r_sout;
  assign shift_cnt = r_cnt;
  assign done      = r_done;

endmodule

// File: tb/tb_shift_reg_ctl.sv
// Self-checking bench for shift_reg_ctl (WIDTH=8, NSTEPS=4): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_shift_reg_ctl;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          sclr = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  ld_data = '0;
  logic          sin = 1'b0;
  logic [W-1:0]  q;
  logic [1:0]    sout;
  logic [CW-1:0] shift_cnt;
  logic          done;

  int checks = 0;
  int failures = 0;

  // reference model state
  int unsigned m_q = 0;
  int unsigned m_sout = 0;
  int unsigned m_cnt = 0;
  bit          m_done = 1'b0;

  localparam int unsigned MASK = (1 << W) - 1;

  shift_reg_ctl #(.WIDTH(W), .NSTEPS(N)) dut (
    .clk(clk), .clr(clr), .sclr(sclr), .en(en), .mode(mode),
    .ld_data(ld_data), .sin(sin), .q(q), .sout(sout),
    .shift_cnt(shift_cnt), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_clear();
    m_q = 0; m_sout = 0; m_cnt = 0; m_done = 1'b0;
  endfunction

  function automatic void model_step(input bit s, input bit e, input int unsigned m,
                                     input int unsigned d, input bit si);
    int unsigned sign;
    if (s) begin
      model_clear();
      return;
    end
    if (!e) return;
    if (m == 1) begin
      m_q = d & MASK; m_sout = 0; m_cnt = 0; m_done = 1'b0;
      return;
    end
    if (m < 2 || m > 6 || m_done) return;
    sign = (m_q >> (W - 1)) & 1;
    case (m)
      2: begin m_sout = m_q % 2; m_q = (m_q / 2) + sign * (1 << (W - 1)); end
      3: begin m_sout = m_q % 4; m_q = (m_q / 4) + sign * (3 << (W - 2)); end
      4: begin m_sout = m_q % 2; m_q = (m_q / 2) + si * (1 << (W - 1)); end
      5: begin m_sout = sign;    m_q = ((m_q * 2) + si) & MASK; end
      default: begin m_sout = m_q % 2; m_q = (m_q / 2) + (m_q % 2) * (1 << (W - 1)); end
    endcase
    m_cnt = m_cnt + 1;
    if (m_cnt == N) m_done = 1'b1;
  endfunction

  task automatic cmp_model(input string tag);
    check({tag, ".q"}, 32'(q), m_q);
    check({tag, ".sout"}, 32'(sout), m_sout);
    check({tag, ".cnt"}, 32'(shift_cnt), m_cnt);
    check({tag, ".done"}, 32'(done), 32'(m_done));
  endtask

  // inputs are applied 1 time unit after an edge and results sampled 1 unit after the next
  task automatic op(input string tag, input bit s, input bit e, input logic [2:0] m,
                    input logic [W-1:0] d, input bit si);
    sclr = s; en = e; mode = m; ld_data = d; sin = si;
    model_step(s, e, m, d, si);
    @(posedge clk); #1;
    $display("%s sclr=%0b en=%0b mode=%0d ld=%h sin=%0b -> q=%h sout=%b cnt=%0d done=%0b",
             tag, s, e, m, d, si, q, sout, shift_cnt, done);
    cmp_model(tag);
  endtask

  initial begin
    // reset held low across edges
    repeat (2) @(posedge clk);
    #1;
    check("rst.q", 32'(q), 0);
    check("rst.sout", 32'(sout), 0);
    check("rst.cnt", 32'(shift_cnt), 0);
    check("rst.done", 32'(done), 0);
    clr = 1'b1;

    // asynchronous reset mid-sequence (q=5A, cnt=2)
    op("t1.load", 0, 1, 3'b001, 8'h69, 0);
    op("t1.ror", 0, 1, 3'b110, 8'h00, 0);
    op("t1.ror", 0, 1, 3'b110, 8'h00, 0);
    check("t1.pre_q", 32'(q), 32'h5A);
    check("t1.pre_cnt", 32'(shift_cnt), 2);
    #2 clr = 1'b0;
    #1;
    model_clear();
    check("t1.async_q", 32'(q), 0);
    check("t1.async_cnt", 32'(shift_cnt), 0);
    cmp_model("t1.async");
    @(posedge clk); #1;
    clr = 1'b1;
    cmp_model("t1.held");

    // arithmetic shifts
    op("t2.load", 0, 1, 3'b001, 8'hA4, 0);
    op("t2.asr2", 0, 1, 3'b011, 8'h00, 0);
    check("t2.asr2_q", 32'(q), 32'hE9);
    check("t2.asr2_sout", 32'(sout), 0);
    op("t2.asr1", 0, 1, 3'b010, 8'h00, 0);
    check("t2.asr1_q", 32'(q), 32'hF4);
    check("t2.asr1_sout", 32'(sout), 1);
    check("t2.asr1_cnt", 32'(shift_cnt), 2);

    // logical shifts and rotate
    op("t3.load", 0, 1, 3'b001, 8'h81, 0);
    op("t3.lsl1", 0, 1, 3'b101, 8'h00, 1);
    check("t3.lsl1_q", 32'(q), 32'h03);
    op("t3.lsr1", 0, 1, 3'b100, 8'h00, 1);
    check("t3.lsr1_q", 32'(q), 32'h81);
    op("t3.ror1", 0, 1, 3'b110, 8'h00, 0);
    check("t3.ror1_q", 32'(q), 32'hC0);
    check("t3.ror1_sout", 32'(sout), 1);

    // done after NSTEPS, shifts blocked, LOAD clears
    op("t4.load", 0, 1, 3'b001, 8'h01, 0);
    for (int i = 0; i < N; i++) op("t4.ror", 0, 1, 3'b110, 8'h00, 0);
    check("t4.done", 32'(done), 1);
    check("t4.cnt", 32'(shift_cnt), N);
    check("t4.q", 32'(q), 32'h10);
    op("t4.ror_blk", 0, 1, 3'b110, 8'h00, 0);
    check("t4.blk_q", 32'(q), 32'h10);
    check("t4.blk_cnt", 32'(shift_cnt), N);
    op("t4.reload", 0, 1, 3'b001, 8'h33, 0);
    check("t4.reload_done", 32'(done), 0);
    check("t4.reload_cnt", 32'(shift_cnt), 0);

    // enable low holds, sclr wins over everything
    op("t5.asr1", 0, 1, 3'b010, 8'h00, 0);
    for (int i = 0; i < 3; i++) op("t5.hold", 0, 0, 3'b010, 8'h00, 0);
    check("t5.hold_q", 32'(q), 32'h19);
    op("t5.sclr", 1, 0, 3'b001, 8'hFF, 0);
    check("t5.sclr_q", 32'(q), 0);
    check("t5.sclr_cnt", 32'(shift_cnt), 0);

    // reserved mode behaves as hold
    op("t6.load", 0, 1, 3'b001, 8'h7E, 0);
    op("t6.rsvd", 0, 1, 3'b111, 8'h00, 1);
    check("t6.rsvd_q", 32'(q), 32'h7E);
    check("t6.rsvd_cnt", 32'(shift_cnt), 0);

    // random operations against the model
    for (int i = 0; i < 300; i++) begin
      bit s, e;
      s = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 7) != 0);
      op("rnd", s, e, 3'($urandom_range(0, 7)), W'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
